// File: rtl/punc_ctrl_fsm.sv
// punc_ctrl_fsm -- multi-cycle control unit for the PUnC LC3 core.
// Sequences FETCH / DECODE / EXEC over a req/ack memory, with a second
// memory phase (IND) for LDI/STI, single-step debug, a memory-wait timeout
// fault and a retired-instruction counter.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   ir, cc_nzp          instruction register and {n,z,p} condition codes
//   mem_ack             memory completes the access this cycle
//   step_en, step_go    single-step enable and release pulse
//   mem_req/mem_we/mem_asel   memory request, write flag, address select
//   ir_ld, mdr_ld, pc_ld, pc_sel, rf_we, rf_wsel, alu_op, cc_ld
//                       datapath load strobes and mux selects
//   halted, fault, retired    status: HALT state, sticky fault, count
module punc_ctrl_fsm #(
  parameter int IR_W    = 16,
  parameter int TMO_W   = 8,
  parameter int TMO_MAX = 200,
  parameter int RET_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IR_W-1:0]  ir,
  input  logic [2:0]       cc_nzp,
  input  logic             mem_ack,
  input  logic             step_en,
  input  logic             step_go,
  output logic             mem_req,
  output logic             mem_we,
  output logic [1:0]       mem_asel,
  output logic             ir_ld,
  output logic             mdr_ld,
  output logic             pc_ld,
  output logic [1:0]       pc_sel,
  output logic             rf_we,
  output logic [1:0]       rf_wsel,
  output logic [1:0]       alu_op,
  output logic             cc_ld,
  output logic             halted,
  output logic [1:0]       fault,
  output logic [RET_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXEC      = 3'd2,
    S_IND       = 3'd3,
    S_STEP_WAIT = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_RTI  = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_RES  = 4'b1101;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_MAX - 1);

  state_t            state_r, case_n_s, state_n;
  logic [1:0]        fault_r, case_fault_s, fault_n;
  logic [RET_W-1:0]  retired_r;
  logic [TMO_W-1:0]  tmo_cnt_r;
  state_t            done_n_s;
  logic              done_s, tmo_hit_s;
  logic [3:0]        opcode_s;
  logic              req_s, we_s, ir_ld_s, mdr_ld_s, pc_ld_s, rf_we_s, cc_ld_s;
  logic [1:0]        asel_s, pc_sel_s, rf_wsel_s, alu_op_s;
  logic              unused_ir_s;

  assign opcode_s    = ir[IR_W-1 -: 4];
  assign unused_ir_s = ^ir;
  // Where a finished instruction goes; step_en only matters at completion.
  assign done_n_s    = step_en ? S_STEP_WAIT : S_FETCH;
  // The last permitted wait cycle without an ack trips the timeout.
  assign tmo_hit_s   = req_s & ~mem_ack & (tmo_cnt_r == TMO_LAST);

  // Per-state strobe decode and nominal next state.
  always_comb begin
    case_n_s     = state_r;
    case_fault_s = fault_r;
    done_s       = 1'b0;
    req_s        = 1'b0;
    we_s         = 1'b0;
    asel_s       = 2'd0;
    ir_ld_s      = 1'b0;
    mdr_ld_s     = 1'b0;
    pc_ld_s      = 1'b0;
    pc_sel_s     = 2'd0;
    rf_we_s      = 1'b0;
    rf_wsel_s    = 2'd0;
    alu_op_s     = 2'd0;
    cc_ld_s      = 1'b0;
    case (state_r)
      S_FETCH: begin
        req_s = 1'b1;
        if (mem_ack) begin
          ir_ld_s  = 1'b1;
          pc_ld_s  = 1'b1;
          case_n_s = S_DECODE;
        end else begin
          case_n_s = S_FETCH;
        end
      end
      S_DECODE: begin
        case (opcode_s)
          OP_RTI, OP_RES: begin
            case_n_s     = S_HALT;
            case_fault_s = 2'd1;
          end
          OP_TRAP: case_n_s = S_HALT;
          default: case_n_s = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (opcode_s)
          OP_ADD, OP_AND, OP_NOT: begin
            rf_we_s  = 1'b1;
            cc_ld_s  = 1'b1;
            alu_op_s = (opcode_s == OP_ADD) ? 2'd0 :
                       (opcode_s == OP_AND) ? 2'd1 : 2'd2;
            done_s   = 1'b1;
          end
          OP_LEA: begin
            rf_we_s   = 1'b1;
            rf_wsel_s = 2'd3;
            cc_ld_s   = 1'b1;
            done_s    = 1'b1;
          end
          OP_BR: begin
            if ((ir[11:9] & cc_nzp) != 3'b000) begin
              pc_ld_s  = 1'b1;
              pc_sel_s = 2'd1;
            end else begin
              pc_ld_s  = 1'b0;
            end
            done_s = 1'b1;
          end
          OP_JMP: begin
            pc_ld_s  = 1'b1;
            pc_sel_s = 2'd3;
            done_s   = 1'b1;
          end
          OP_JSR: begin
            // Link write and PC load share a cycle; the RF read port still
            // holds the old base register, so JSRR through R7 is safe.
            rf_we_s   = 1'b1;
            rf_wsel_s = 2'd2;
            pc_ld_s   = 1'b1;
            pc_sel_s  = ir[11] ? 2'd2 : 2'd3;
            done_s    = 1'b1;
          end
          OP_LD, OP_LDR: begin
            req_s  = 1'b1;
            asel_s = (opcode_s == OP_LD) ? 2'd1 : 2'd2;
            if (mem_ack) begin
              rf_we_s   = 1'b1;
              rf_wsel_s = 2'd1;
              cc_ld_s   = 1'b1;
              done_s    = 1'b1;
            end else begin
              done_s    = 1'b0;
            end
          end
          OP_ST, OP_STR: begin
            req_s  = 1'b1;
            we_s   = 1'b1;
            asel_s = (opcode_s == OP_ST) ? 2'd1 : 2'd2;
            done_s = mem_ack;
          end
          OP_LDI, OP_STI: begin
            // First phase always reads the pointer word into MDR.
            req_s  = 1'b1;
            asel_s = 2'd1;
            if (mem_ack) begin
              mdr_ld_s = 1'b1;
              case_n_s = S_IND;
            end else begin
              case_n_s = S_EXEC;
            end
          end
          default: case_n_s = S_HALT;
        endcase
        if (done_s) begin
          case_n_s = done_n_s;
        end else begin
          case_fault_s = fault_r;
        end
      end
      S_IND: begin
        req_s  = 1'b1;
        asel_s = 2'd3;
        we_s   = (opcode_s == OP_STI);
        if (mem_ack) begin
          if (opcode_s == OP_LDI) begin
            rf_we_s   = 1'b1;
            rf_wsel_s = 2'd1;
            cc_ld_s   = 1'b1;
          end else begin
            rf_we_s   = 1'b0;
          end
          done_s   = 1'b1;
          case_n_s = done_n_s;
        end else begin
          case_n_s = S_IND;
        end
      end
      S_STEP_WAIT: begin
        if (step_go) begin
          case_n_s = S_FETCH;
        end else begin
          case_n_s = S_STEP_WAIT;
        end
      end
      S_HALT:  case_n_s = S_HALT;
      default: case_n_s = S_FETCH;
    endcase
  end

  // Timeout overrides the nominal transition.
  always_comb begin
    if (tmo_hit_s) begin
      state_n = S_HALT;
      fault_n = 2'd2;
    end else begin
      state_n = case_n_s;
      fault_n = case_fault_s;
    end
  end

  // Output strobes, forced quiet while reset is held.
  always_comb begin
    if (rst) begin
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      mem_asel = 2'd0;
      ir_ld    = 1'b0;
      mdr_ld   = 1'b0;
      pc_ld    = 1'b0;
      pc_sel   = 2'd0;
      rf_we    = 1'b0;
      rf_wsel  = 2'd0;
      alu_op   = 2'd0;
      cc_ld    = 1'b0;
    end else begin
      mem_req  = req_s;
      mem_we   = we_s;
      mem_asel = asel_s;
      ir_ld    = ir_ld_s;
      mdr_ld   = mdr_ld_s;
      pc_ld    = pc_ld_s;
      pc_sel   = pc_sel_s;
      rf_we    = rf_we_s;
      rf_wsel  = rf_wsel_s;
      alu_op   = alu_op_s;
      cc_ld    = cc_ld_s;
    end
  end

  // State, fault, retired counter and memory-wait counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= S_FETCH;
      fault_r   <= 2'd0;
      retired_r <= {RET_W{1'b0}};
      tmo_cnt_r <= {TMO_W{1'b0}};
    end else begin
      state_r <= state_n;
      fault_r <= fault_n;
      if (done_s) begin
        retired_r <= retired_r + RET_W'(1);
      end
      if (state_n != state_r) begin
        tmo_cnt_r <= {TMO_W{1'b0}};
      end else if (req_s && !mem_ack) begin
        tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
      end
    end
  end

  assign halted  = (state_r == S_HALT);
  assign fault   = fault_r;
  assign retired = retired_r;

endmodule

// File: tb/tb_punc_ctrl_fsm.sv
// Directed bench for punc_ctrl_fsm with TMO_MAX=5. Inputs change on the
// falling edge, outputs are sampled 1 time unit later.
module tb_punc_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst, mem_ack, step_en, step_go;
  logic [15:0] ir;
  logic [2:0]  cc_nzp;
  logic        mem_req, mem_we, ir_ld, mdr_ld, pc_ld, rf_we, cc_ld, halted;
  logic [1:0]  mem_asel, pc_sel, rf_wsel, alu_op, fault;
  logic [31:0] retired;
  int          err_cnt = 0;
  int          chk_cnt = 0;
  int          exp_ret = 0;

  punc_ctrl_fsm #(.IR_W(16), .TMO_W(8), .TMO_MAX(5), .RET_W(32)) dut (
    .clk(clk), .rst(rst), .ir(ir), .cc_nzp(cc_nzp), .mem_ack(mem_ack),
    .step_en(step_en), .step_go(step_go), .mem_req(mem_req), .mem_we(mem_we),
    .mem_asel(mem_asel), .ir_ld(ir_ld), .mdr_ld(mdr_ld), .pc_ld(pc_ld),
    .pc_sel(pc_sel), .rf_we(rf_we), .rf_wsel(rf_wsel), .alu_op(alu_op),
    .cc_ld(cc_ld), .halted(halted), .fault(fault), .retired(retired)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic ack);
    @(negedge clk);
    mem_ack = ack;
    #1;
  endtask

  // FETCH with 'waits' stalled cycles, then the DECODE cycle.
  task automatic fetch(input logic [15:0] iv, input int waits, input string tag);
    for (int i = 0; i < waits; i++) begin
      drive(1'b0);
      if (i == 0) begin
        ir = iv;
        check_val({tag, "_ret"}, retired, exp_ret);
      end
      check_val({tag, "_wreq"}, {31'd0, mem_req}, 32'd1);
      check_val({tag, "_wirld"}, {31'd0, ir_ld}, 32'd0);
    end
    drive(1'b1);
    if (waits == 0) begin
      ir = iv;
      check_val({tag, "_ret"}, retired, exp_ret);
    end
    check_val({tag, "_irld"}, {31'd0, ir_ld}, 32'd1);
    check_val({tag, "_pcld"}, {31'd0, pc_ld}, 32'd1);
    check_val({tag, "_asel"}, {30'd0, mem_asel}, 32'd0);
    drive(1'b0);
    check_val({tag, "_dreq"}, {31'd0, mem_req}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; mem_ack = 1'b0; ir = 16'h0000; cc_nzp = 3'b000;
    step_en = 1'b0; step_go = 1'b0;
    drive(1'b0);
    drive(1'b0);
    check_val("rst_req", {31'd0, mem_req}, 32'd0);
    check_val("rst_halt", {31'd0, halted}, 32'd0);
    check_val("rst_fault", {30'd0, fault}, 32'd0);
    check_val("rst_ret", retired, 32'd0);

    // ADD R1,R1,#1 with immediate acks
    @(negedge clk); rst = 1'b0; mem_ack = 1'b1; ir = 16'h1261; #1;
    check_val("add_freq", {31'd0, mem_req}, 32'd1);
    check_val("add_irld", {31'd0, ir_ld}, 32'd1);
    check_val("add_pcsel", {30'd0, pc_sel}, 32'd0);
    drive(1'b0);
    check_val("add_dreq", {31'd0, mem_req}, 32'd0);
    drive(1'b0);
    check_val("add_rfwe", {31'd0, rf_we}, 32'd1);
    check_val("add_wsel", {30'd0, rf_wsel}, 32'd0);
    check_val("add_alu", {30'd0, alu_op}, 32'd0);
    check_val("add_cc", {31'd0, cc_ld}, 32'd1);
    check_val("add_ret0", retired, 32'd0);
    exp_ret = 1;

    // LD with 3-cycle delayed acks on fetch and data phase
    fetch(16'h2405, 3, "ld");
    for (int i = 0; i < 3; i++) begin
      drive(1'b0);
      check_val("ld_wreq", {31'd0, mem_req}, 32'd1);
      check_val("ld_wasel", {30'd0, mem_asel}, 32'd1);
      check_val("ld_wrfwe", {31'd0, rf_we}, 32'd0);
    end
    drive(1'b1);
    check_val("ld_rfwe", {31'd0, rf_we}, 32'd1);
    check_val("ld_wsel", {30'd0, rf_wsel}, 32'd1);
    check_val("ld_cc", {31'd0, cc_ld}, 32'd1);
    exp_ret = 2;

    // LDI: pointer read then indirect read
    fetch(16'hA602, 0, "ldi");
    drive(1'b1);
    check_val("ldi_asel1", {30'd0, mem_asel}, 32'd1);
    check_val("ldi_mdr", {31'd0, mdr_ld}, 32'd1);
    check_val("ldi_rfwe0", {31'd0, rf_we}, 32'd0);
    drive(1'b1);
    check_val("ldi_asel3", {30'd0, mem_asel}, 32'd3);
    check_val("ldi_mdr0", {31'd0, mdr_ld}, 32'd0);
    check_val("ldi_rfwe", {31'd0, rf_we}, 32'd1);
    check_val("ldi_wsel", {30'd0, rf_wsel}, 32'd1);
    check_val("ldi_we", {31'd0, mem_we}, 32'd0);
    exp_ret = 3;

    // STI: pointer read then indirect write
    fetch(16'hB602, 0, "sti");
    drive(1'b1);
    check_val("sti_we0", {31'd0, mem_we}, 32'd0);
    check_val("sti_mdr", {31'd0, mdr_ld}, 32'd1);
    drive(1'b1);
    check_val("sti_we", {31'd0, mem_we}, 32'd1);
    check_val("sti_asel3", {30'd0, mem_asel}, 32'd3);
    check_val("sti_rfwe", {31'd0, rf_we}, 32'd0);
    exp_ret = 4;

    // BRz taken and not taken
    fetch(16'h0403, 0, "brt");
    cc_nzp = 3'b010;
    drive(1'b0);
    check_val("brt_pcld", {31'd0, pc_ld}, 32'd1);
    check_val("brt_pcsel", {30'd0, pc_sel}, 32'd1);
    exp_ret = 5;
    fetch(16'h0403, 0, "brn");
    cc_nzp = 3'b100;
    drive(1'b0);
    check_val("brn_pcld", {31'd0, pc_ld}, 32'd0);
    exp_ret = 6;

    // JSR with PC-relative offset
    fetch(16'h4800, 0, "jsr");
    drive(1'b0);
    check_val("jsr_rfwe", {31'd0, rf_we}, 32'd1);
    check_val("jsr_wsel", {30'd0, rf_wsel}, 32'd2);
    check_val("jsr_pcld", {31'd0, pc_ld}, 32'd1);
    check_val("jsr_pcsel", {30'd0, pc_sel}, 32'd2);
    exp_ret = 7;

    // Single step: park in STEP_WAIT until step_go
    fetch(16'h1261, 0, "stp");
    step_en = 1'b1;
    drive(1'b0);
    check_val("stp_rfwe", {31'd0, rf_we}, 32'd1);
    exp_ret = 8;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0);
      check_val("stp_wait", {31'd0, mem_req}, 32'd0);
    end
    check_val("stp_ret", retired, exp_ret);
    @(negedge clk); step_go = 1'b1; #1;
    check_val("stp_go", {31'd0, mem_req}, 32'd0);
    @(negedge clk); step_go = 1'b0; step_en = 1'b0; #1;
    check_val("stp_fetch", {31'd0, mem_req}, 32'd1);

    // Timeout: that fetch never gets an ack; 5 wait cycles then HALT
    for (int i = 0; i < 4; i++) begin
      drive(1'b0);
      check_val("tmo_req", {31'd0, mem_req}, 32'd1);
      check_val("tmo_halt0", {31'd0, halted}, 32'd0);
    end
    drive(1'b0);
    check_val("tmo_halt", {31'd0, halted}, 32'd1);
    check_val("tmo_fault", {30'd0, fault}, 32'd2);
    check_val("tmo_req0", {31'd0, mem_req}, 32'd0);
    check_val("tmo_ret", retired, exp_ret);
    drive(1'b1);
    check_val("halt_abs", {31'd0, halted}, 32'd1);
    check_val("halt_irld", {31'd0, ir_ld}, 32'd0);

    // Reset clears, then reserved opcode faults
    @(negedge clk); rst = 1'b1; #1;
    drive(1'b0);
    check_val("rst2_halt", {31'd0, halted}, 32'd0);
    check_val("rst2_fault", {30'd0, fault}, 32'd0);
    check_val("rst2_ret", retired, 32'd0);
    @(negedge clk); rst = 1'b0; mem_ack = 1'b1; ir = 16'hD000; #1;
    check_val("ill_irld", {31'd0, ir_ld}, 32'd1);
    drive(1'b0);
    drive(1'b0);
    check_val("ill_halt", {31'd0, halted}, 32'd1);
    check_val("ill_fault", {30'd0, fault}, 32'd1);
    check_val("ill_ret", retired, 32'd0);

    // Ack on the last allowed wait cycle wins over the timeout
    @(negedge clk); rst = 1'b1; #1;
    drive(1'b0);
    @(negedge clk); rst = 1'b0; mem_ack = 1'b0; ir = 16'h1261; #1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0);
    end
    drive(1'b1);
    check_val("edge_irld", {31'd0, ir_ld}, 32'd1);
    drive(1'b0);
    check_val("edge_halt", {31'd0, halted}, 32'd0);
    check_val("edge_fault", {30'd0, fault}, 32'd0);
    drive(1'b0);
    check_val("edge_rfwe", {31'd0, rf_we}, 32'd1);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
